alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit_pkg.sv | 51 +++++
 rtl/alu_exec_unit_if.sv | 25 ++
 rtl/alu_exec_unit_mul.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 122 ++++++++++++
 tb/tb_alu_exec_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALUop/funct codes, FSM state encoding and op decode for the execute unit
// and the opcode decoder.
package alu_defs;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h18;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [2:0] {K_AND, K_OR, K_ADD, K_SUB, K_SLT, K_MUL, K_ILL} op_kind_e;

  // Collapses the two-level ALUop/funct encoding into one operation kind.
  function automatic op_kind_e decode_op(input logic [2:0] op, input logic [5:0] fn);
    op_kind_e k;
    k = K_ILL;
    case (op)
      ALU_AND: k = K_AND;
      ALU_OR:  k = K_OR;
      ALU_ADD: k = K_ADD;
      ALU_SUB: k = K_SUB;
      ALU_SLT: k = K_SLT;
      ALU_RTYPE: begin
        case (fn)
          F_ADD:   k = K_ADD;
          F_SUB:   k = K_SUB;
          F_AND:   k = K_AND;
          F_OR:    k = K_OR;
          F_SLT:   k = K_SLT;
          F_MUL:   k = K_MUL;
          default: k = K_ILL;
        endcase
      end
      default: k = K_ILL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the issue side and the execute unit.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, alu_op, funct, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, err
  );

  modport slave (
    input  in_valid, alu_op, funct, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, ovf, err
  );
endinterface

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low half of product.
// done_o flags the last iteration so the caller can register prod_o on that same edge.
module seq_shift_add_mul #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign prod_o = acc_d;
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative multiply, with
// valid/ready on both sides and a registered result/flag bundle.
module alu_exec_unit
  import alu_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input logic           clk,
  input logic           reset,
  alu_exec_unit_if.slave bus
);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;

  op_kind_e         kind;
  logic             accept;
  logic [WIDTH-1:0] a, b, sum, diff, alu_res;
  logic             alu_ovf, alu_err;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign a      = bus.op_a;
  assign b      = bus.op_b;
  assign kind   = decode_op(bus.alu_op, bus.funct);
  assign accept = (state_q == S_IDLE) && bus.in_valid;
  assign sum    = a + b;
  assign diff   = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (kind)
      K_AND: alu_res = a & b;
      K_OR:  alu_res = a | b;
      K_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      K_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      K_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      K_MUL:   alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  seq_shift_add_mul #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (accept && (kind == K_MUL)),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (kind == K_MUL) begin
            state_d = S_MUL;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            err_d    = alu_err;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d  = S_DONE;
          result_d = mul_prod;
          zero_d   = (mul_prod == '0);
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end else if (!mul_busy) begin
          // Multiplier lost its job without finishing; never strand the FSM here.
          state_d = S_IDLE;
        end
      end
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, random ops vs. an arithmetic
// model, and hand sequences for backpressure and reset during multiply.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: operation semantics straight from the ISA rules, using 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z, output logic o,
                                output logic e, output int lat);
    int k;
    longint sa, sb, s;
    longint unsigned ua, ub, p;
    longint maxp, minn;
    maxp = 64'sd2147483647;
    minn = -64'sd2147483648;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'b000: k = 0;
      3'b001: k = 1;
      3'b101: k = 2;
      3'b110: k = 3;
      3'b100: k = 4;
      3'b111: begin
        case (fn)
          6'h24: k = 0;
          6'h25: k = 1;
          6'h20: k = 2;
          6'h22: k = 3;
          6'h2A: k = 4;
          6'h18: k = 5;
          default: k = 6;
        endcase
      end
      default: k = 6;
    endcase
    r = 32'd0; o = 1'b0; e = 1'b0; lat = 1;
    case (k)
      0: r = a & b;
      1: r = a | b;
      2: begin s = sa + sb; r = s[31:0]; o = (s > maxp) || (s < minn); end
      3: begin s = sa - sb; r = s[31:0]; o = (s > maxp) || (s < minn); end
      4: r = (sa < sb) ? 32'd1 : 32'd0;
      5: begin p = ua * ub; r = p[31:0]; lat = 33; end
      default: e = 1'b1;
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic run_vec(input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic eo,
                         input logic ee, input int elat, input string nm);
    int n;
    int lat;
    bit leak;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk({nm, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.alu_op = op; bus.funct = fn; bus.op_a = a; bus.op_b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom;
    lat = 1; leak = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "/latency"}, 32'(lat), 32'(elat));
    chk({nm, "/busy_ready"}, 32'(leak), 32'd0);
    chk({nm, "/result"}, bus.result, er);
    chk({nm, "/flags"}, {29'd0, bus.zero, bus.ovf, bus.err}, {29'd0, ez, eo, ee});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "/drop"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] edge_v[6];
    logic [5:0]  legal_fn[6];
    logic [2:0]  rop;
    logic [5:0]  rfn;
    logic [31:0] ra, rb, mr;
    logic        mz, mo, me;
    int          ml;

    edge_v   = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
    legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18};

    tbl[0]  = '{3'b101, 6'h00, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b0, 1};
    tbl[1]  = '{3'b110, 6'h00, 32'd5,         32'd5,         32'h0,         1'b1, 1'b0, 1'b0, 1};
    tbl[2]  = '{3'b100, 6'h00, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1'b0, 1};
    tbl[3]  = '{3'b111, 6'h18, 32'd12345,     32'd678,       32'd8369910,   1'b0, 1'b0, 1'b0, 33};
    tbl[4]  = '{3'b111, 6'h18, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33};
    tbl[5]  = '{3'b010, 6'h00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         1'b1, 1'b0, 1'b1, 1};
    tbl[6]  = '{3'b111, 6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         1'b1, 1'b0, 1'b1, 1};
    tbl[7]  = '{3'b001, 6'h00, 32'd1,         32'd2,         32'd3,         1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{3'b110, 6'h00, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
    tbl[9]  = '{3'b111, 6'h20, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 1'b0, 1};
    tbl[10] = '{3'b111, 6'h2A, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 1'b0, 1};
    tbl[11] = '{3'b011, 6'h20, 32'h5,         32'h6,         32'h0,         1'b1, 1'b0, 1'b1, 1};
    tbl[12] = '{3'b111, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.alu_op = 3'b000; bus.funct = 6'h00; bus.op_a = '0; bus.op_b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset/valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    chk("reset/result", bus.result, 32'h0);
    chk("reset/flags", {29'd0, bus.zero, bus.ovf, bus.err}, 32'd0);

    for (int i = 0; i < 13; i++)
      run_vec(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].z, tbl[i].o,
              tbl[i].e, tbl[i].lat, $sformatf("vec%0d", i));

    // Backpressure: result held, new request ignored until the result is taken.
    bus.alu_op = 3'b000; bus.funct = 6'h00; bus.op_a = 32'hF0F0_F0F0; bus.op_b = 32'hFF00_FF00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp/valid", 32'(bus.out_valid), 32'd1);
    bus.alu_op = 3'b001; bus.op_a = 32'd1; bus.op_b = 32'd2;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp/hold%0d", c), bus.result, 32'hF000_F000);
      chk($sformatf("bp/ready%0d", c), {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp/release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp/next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp/next_result", bus.result, 32'd3);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of a multiply discards it.
    bus.alu_op = 3'b111; bus.funct = 6'h18; bus.op_a = 32'd12345; bus.op_b = 32'd678;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mulrst/valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    chk("mulrst/flags", {29'd0, bus.zero, bus.ovf, bus.err}, 32'd0);
    chk("mulrst/result", bus.result, 32'd0);
    run_vec(3'b001, 6'h00, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1, "mulrst/or");

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 5)];
      ra  = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      model(rop, rfn, ra, rb, mr, mz, mo, me, ml);
      run_vec(rop, rfn, ra, rb, mr, mz, mo, me, ml, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
